lpc_host_master: RTL
====================

Name: lpc_host_master

Overview:
- LPC host-side initiator. Generates LPC I/O read and I/O write cycles on the frame and data-bus pins on request from internal logic.
- Counterpart to the CPLD's LPC target decoder and register block. Used for board-level self-test, and by the bench to drive the target from within the CPLD design.
- Handles turn-around (TAR), SYNC wait states, target error SYNC, and no-response abort.

Parameters:
- NORESP_MAX, 3, SYNC clocks with no valid SYNC code before the host aborts.
- WAIT_MAX, 1023, SYNC clocks of short/long wait before the host aborts; used only with LPC_HOST_TIMEOUT_EN.

Ports:
- LpcClock  in  1  33 MHz LPC clock
- PciReset  in  1  reset, asynchronous, active-low
- Req  in  1  start a cycle; sampled only in IDLE
- ReqWr  in  1  1 = I/O write, 0 = I/O read; captured with Req
- ReqAddr  in  16  I/O address; captured with Req
- ReqWData  in  8  write data; captured with Req
- Busy  out  1  high whenever the FSM is not in IDLE
- Done  out  1  one-clock pulse at cycle completion
- RData  out  8  read data; valid from Done, held until the next Done
- Error  out  1  status of the last cycle (error SYNC or abort); valid with Done, held until the next Done
- LpcFrameOut  out  1  LFRAME#, active low
- LpcBusOut  out  4  LAD[3:0] drive value
- LpcBusOe  out  1  LAD output enable
- LpcBusIn  in  4  LAD[3:0] sampled value

Behaviour:
- Reset values: Busy=0, Done=0, RData=8'h00, Error=0, LpcFrameOut=1, LpcBusOut=4'hF, LpcBusOe=0, FSM=IDLE.
- Reset mid-cycle returns immediately to these values. No abort sequence is driven.
- All outputs are registered.
- IDLE:
  - Frame=1, Oe=0.
  - On Req=1, capture Wr/Addr/WData and enter START next clock.
  - Req is ignored while Busy.
- START, 1 clock: Frame=0, Oe=1, Bus=4'h0.
- CTDIR, 1 clock: Frame=1, Bus=4'h2 for write, 4'h0 for read.
- ADDR, 4 clocks: Addr[15:12], [11:8], [7:4], [3:0], in that order (MSB nibble first).
- WDATA, 2 clocks, write only: WData[3:0], then WData[7:4].
- TAR1, 2 clocks: clock 1 drives Bus=4'hF with Oe=1; clock 2 has Oe=0.
- SYNC: sample LpcBusIn every clock.
  - 4'h0 (ready): go to RDATA (read) or TAR2 (write).
  - 4'hA (error): set error flag, then proceed exactly as for ready.
  - 4'h5 / 4'h6 (short/long wait): stay in SYNC; the no-response count is cleared.
  - Any other value: increment the no-response count. When it reaches NORESP_MAX, enter ABORT.
- RDATA, 2 clocks, read only: capture LpcBusIn into a data register, low nibble first.
- TAR2, 2 clocks: host keeps Oe=0. Then return to IDLE with Done=1, and RData/Error updated in that same clock.
- ABORT, 4 clocks: Frame=0, Oe=1, Bus=4'hF. Then IDLE with Done=1 and Error=1. RData is unchanged after an abort.
- Latency with zero wait states: Req sampled at edge k, START in clock k+1, Done high in clock k+14, for both read and write.
- A new Req in the Done clock is accepted; back-to-back cycles have no idle gap beyond that clock.
- Width rules:
  - Wait counter is 10 bits and saturates at WAIT_MAX.
  - No-response counter is 2 bits.
  - Both counters clear on entry to SYNC.

Optional Feature:
- Macro: LPC_HOST_TIMEOUT_EN.
- Defined: short/long wait SYNC clocks increment the wait counter. When it reaches WAIT_MAX, enter ABORT (Error=1).
- Undefined: wait SYNCs are honoured indefinitely; the wait counter logic is not synthesized.
- The no-response abort is present in both builds.

Decomposition:
- Package lpc_host_pkg:
  - FSM state enum: IDLE, START, CTDIR, ADDR, WDATA, TAR1, SYNC, RDATA, TAR2, ABORT.
  - Nibble constants: LPC_START=4'h0, CT_IO_RD=4'h0, CT_IO_WR=4'h2, SYNC_READY=4'h0, SYNC_SWAIT=4'h5, SYNC_LWAIT=4'h6, SYNC_ERR=4'hA, LAD_IDLE=4'hF.
  - Phase length constants: ADDR_NIBS=4, DATA_NIBS=2, TAR_CLKS=2, ABORT_CLKS=4.
- Sub-module lpc_host_sync_mon:
  - Holds the no-response and wait counters.
  - Decodes the SYNC nibble into ready / error / wait / abort strobes.
  - The main FSM stays in lpc_host_master.

Test Plan:
- Write: Addr=16'h0809, WData=8'hA5, target SYNC=4'h0 first clock -> LAD sequence 0,2,0,8,0,9,5,A,F; Done at clock 14; Error=0.
- Read: Addr=16'h0801, target SYNC=4'h0, data nibbles 3 then C -> RData=8'hC3 at Done (clock 14); Oe=0 from TAR1 clock 2 through TAR2.
- Read, target returns 4'h6 for 20 clocks then 4'h0 -> Done delayed by exactly 20 clocks; Error=0.
- Write, target drives 4'hF in SYNC -> ABORT after 3 clocks; Frame low 4 clocks; Done with Error=1.
- Read with target SYNC=4'hA, data 8'h7E -> RData=8'h7E, Error=1. With LPC_HOST_TIMEOUT_EN and WAIT_MAX=16, continuous 4'h5 -> abort after 16 wait clocks.
- PciReset asserted during ADDR -> next clock Frame=1, Oe=0, Busy=0, no Done. Req issued in a Done clock -> START on the next clock.

Source files
------------

// File: rtl/lpc_host_pkg.sv
// -----------------------------------------------------------------------------
// lpc_host_pkg
// Shared types and constants for the LPC host-side initiator:
//   - state_t      : host cycle FSM states
//   - LAD nibbles  : START, cycle-type/direction, SYNC codes, idle level
//   - phase sizes  : clocks spent in ADDR, data, turn-around and ABORT phases
//   - addr_nib()   : picks one address nibble, most significant nibble first
// -----------------------------------------------------------------------------
package lpc_host_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    CTDIR,
    ADDR,
    WDATA,
    TAR1,
    SYNC,
    RDATA,
    TAR2,
    ABORT
  } state_t;

  localparam logic [3:0] LPC_START  = 4'h0;
  localparam logic [3:0] CT_IO_RD   = 4'h0;
  localparam logic [3:0] CT_IO_WR   = 4'h2;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_SWAIT = 4'h5;
  localparam logic [3:0] SYNC_LWAIT = 4'h6;
  localparam logic [3:0] SYNC_ERR   = 4'hA;
  localparam logic [3:0] LAD_IDLE   = 4'hF;

  localparam int ADDR_NIBS  = 4;
  localparam int DATA_NIBS  = 2;
  localparam int TAR_CLKS   = 2;
  localparam int ABORT_CLKS = 4;

  // idx 0 returns addr[15:12], idx 3 returns addr[3:0].
  function automatic logic [3:0] addr_nib(input logic [15:0] addr, input logic [1:0] idx);
    logic [15:0] shifted;
    shifted = addr << {idx, 2'b00};
    return shifted[15:12];
  endfunction

endpackage

// File: rtl/lpc_host_master_if.sv
// -----------------------------------------------------------------------------
// lpc_host_master_if
// Request/status handshake plus LPC pin bundle of the host initiator.
//   Req, ReqWr, ReqAddr, ReqWData : cycle request from internal logic
//   Busy, Done, RData, Error      : cycle status back to internal logic
//   LpcFrameOut, LpcBusOut, LpcBusOe, LpcBusIn : LFRAME# and LAD[3:0] pins
// Modports:
//   master : the lpc_host_master itself
//   slave  : the requesting logic / LAD target side
// -----------------------------------------------------------------------------
interface lpc_host_master_if;

  logic        Req;
  logic        ReqWr;
  logic [15:0] ReqAddr;
  logic [7:0]  ReqWData;
  logic        Busy;
  logic        Done;
  logic [7:0]  RData;
  logic        Error;
  logic        LpcFrameOut;
  logic [3:0]  LpcBusOut;
  logic        LpcBusOe;
  logic [3:0]  LpcBusIn;

  modport master (
    input  Req, ReqWr, ReqAddr, ReqWData, LpcBusIn,
    output Busy, Done, RData, Error, LpcFrameOut, LpcBusOut, LpcBusOe
  );

  modport slave (
    output Req, ReqWr, ReqAddr, ReqWData, LpcBusIn,
    input  Busy, Done, RData, Error, LpcFrameOut, LpcBusOut, LpcBusOe
  );

endinterface

// File: rtl/lpc_host_sync_mon.sv
// -----------------------------------------------------------------------------
// lpc_host_sync_mon
// Watches LAD during the SYNC phase and tells the host FSM what to do next.
// Ports:
//   LpcClock, PciReset : clock, asynchronous active-low reset
//   in_sync            : host FSM is in SYNC this clock
//   clear              : host FSM enters SYNC next clock; zero both counters
//   lad                : sampled LAD[3:0]
//   sync_ready         : target reported ready (4'h0)
//   sync_error         : target reported error (4'hA); cycle still completes
//   sync_abort         : give up on the target and run the ABORT sequence
// Build option: LPC_HOST_TIMEOUT_EN adds a 10-bit saturating wait counter
// that aborts after WAIT_MAX short/long wait SYNCs. Without it, waits are
// honoured forever and WAIT_MAX has no effect.
// -----------------------------------------------------------------------------
module lpc_host_sync_mon
  import lpc_host_pkg::*;
#(
  parameter int NORESP_MAX = 3,
  parameter int WAIT_MAX   = 1023
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       in_sync,
  input  logic       clear,
  input  logic [3:0] lad,
  output logic       sync_ready,
  output logic       sync_error,
  output logic       sync_abort
);

  localparam logic [1:0] NORESP_LAST = 2'(NORESP_MAX - 1);

  logic       is_ready;
  logic       is_error;
  logic       is_wait;
  logic       is_other;
  logic       noresp_hit;
  logic       wait_hit;
  logic [1:0] noresp_cnt;

  assign is_ready = (lad == SYNC_READY);
  assign is_error = (lad == SYNC_ERR);
  assign is_wait  = (lad == SYNC_SWAIT) || (lad == SYNC_LWAIT);
  assign is_other = !(is_ready || is_error || is_wait);

  // Abort on the clock that would bring the count up to NORESP_MAX.
  assign noresp_hit = in_sync && is_other && (noresp_cnt == NORESP_LAST);

  // A wait SYNC proves the target is alive, so it restarts the no-response run.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      noresp_cnt <= 2'd0;
    end else if (clear) begin
      noresp_cnt <= 2'd0;
    end else if (in_sync) begin
      if (is_wait) begin
        noresp_cnt <= 2'd0;
      end else if (is_other) begin
        noresp_cnt <= noresp_cnt + 2'd1;
      end
    end
  end

`ifdef LPC_HOST_TIMEOUT_EN
  localparam logic [9:0] WAIT_LAST = 10'(WAIT_MAX - 1);
  localparam logic [9:0] WAIT_SAT  = 10'(WAIT_MAX);

  logic [9:0] wait_cnt;

  assign wait_hit = in_sync && is_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      wait_cnt <= 10'd0;
    end else if (clear) begin
      wait_cnt <= 10'd0;
    end else if (in_sync && is_wait && (wait_cnt != WAIT_SAT)) begin
      wait_cnt <= wait_cnt + 10'd1;
    end
  end
`else
  assign wait_hit = 1'b0;
`endif

  assign sync_ready = in_sync && is_ready;
  assign sync_error = in_sync && is_error;
  assign sync_abort = noresp_hit || wait_hit;

endmodule

// File: rtl/lpc_host_master.sv
// -----------------------------------------------------------------------------
// lpc_host_master
// LPC host-side initiator: runs one I/O read or I/O write cycle on LFRAME#/LAD
// per request, including turn-around, SYNC wait states, target error SYNC and
// the no-response abort.
// Ports:
//   LpcClock : 33 MHz LPC clock
//   PciReset : asynchronous active-low reset; drops any cycle without an abort
//   lpc      : lpc_host_master_if.master (request/status + LPC pins)
// Zero-wait latency: Req sampled at edge k, START in clock k+1, Done in k+14.
// All outputs are registered; every next-clock pin value is set alongside
// the state transition that leads into that clock.
// Build option: LPC_HOST_TIMEOUT_EN enables the wait-state timeout
// (see lpc_host_sync_mon).
// -----------------------------------------------------------------------------
module lpc_host_master
  import lpc_host_pkg::*;
#(
  parameter int NORESP_MAX = 3,
  parameter int WAIT_MAX   = 1023
) (
  input logic               LpcClock,
  input logic               PciReset,
  lpc_host_master_if.master lpc
);

  localparam logic [1:0] ADDR_LAST  = 2'(ADDR_NIBS - 1);
  localparam logic [1:0] DATA_LAST  = 2'(DATA_NIBS - 1);
  localparam logic [1:0] TAR_LAST   = 2'(TAR_CLKS - 1);
  localparam logic [1:0] ABORT_LAST = 2'(ABORT_CLKS - 1);

  state_t      state;
  logic [1:0]  phase;     // clock index inside multi-clock phases
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [7:0]  data_q;    // read data assembled during RDATA
  logic        err_q;     // target reported error SYNC in this cycle

  logic sync_ready;
  logic sync_error;
  logic sync_abort;

  lpc_host_sync_mon #(
    .NORESP_MAX (NORESP_MAX),
    .WAIT_MAX   (WAIT_MAX)
  ) u_sync_mon (
    .LpcClock   (LpcClock),
    .PciReset   (PciReset),
    .in_sync    (state == SYNC),
    .clear      ((state == TAR1) && (phase == TAR_LAST)),
    .lad        (lpc.LpcBusIn),
    .sync_ready (sync_ready),
    .sync_error (sync_error),
    .sync_abort (sync_abort)
  );

  // NOTE: all state and registered outputs use non-blocking assignments so
  // every read in this block sees the value from before the clock edge.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      state           <= IDLE;
      phase           <= 2'd0;
      wr_q            <= 1'b0;
      addr_q          <= 16'h0000;
      wdata_q         <= 8'h00;
      data_q          <= 8'h00;
      err_q           <= 1'b0;
      lpc.Busy        <= 1'b0;
      lpc.Done        <= 1'b0;
      lpc.RData       <= 8'h00;
      lpc.Error       <= 1'b0;
      lpc.LpcFrameOut <= 1'b1;
      lpc.LpcBusOut   <= LAD_IDLE;
      lpc.LpcBusOe    <= 1'b0;
    end else begin
      lpc.Done <= 1'b0;

      unique case (state)
        IDLE: begin
          lpc.LpcFrameOut <= 1'b1;
          lpc.LpcBusOe    <= 1'b0;
          lpc.LpcBusOut   <= LAD_IDLE;
          if (lpc.Req) begin
            wr_q            <= lpc.ReqWr;
            addr_q          <= lpc.ReqAddr;
            wdata_q         <= lpc.ReqWData;
            err_q           <= 1'b0;
            state           <= START;
            lpc.Busy        <= 1'b1;
            lpc.LpcFrameOut <= 1'b0;
            lpc.LpcBusOe    <= 1'b1;
            lpc.LpcBusOut   <= LPC_START;
          end
        end

        START: begin
          state           <= CTDIR;
          lpc.LpcFrameOut <= 1'b1;
          lpc.LpcBusOut   <= wr_q ? CT_IO_WR : CT_IO_RD;
        end

        CTDIR: begin
          state         <= ADDR;
          phase         <= 2'd0;
          lpc.LpcBusOut <= addr_nib(addr_q, 2'd0);
        end

        ADDR: begin
          if (phase == ADDR_LAST) begin
            phase <= 2'd0;
            if (wr_q) begin
              state         <= WDATA;
              lpc.LpcBusOut <= wdata_q[3:0];
            end else begin
              state         <= TAR1;
              lpc.LpcBusOut <= LAD_IDLE;
            end
          end else begin
            phase         <= phase + 2'd1;
            lpc.LpcBusOut <= addr_nib(addr_q, phase + 2'd1);
          end
        end

        WDATA: begin
          if (phase == DATA_LAST) begin
            state         <= TAR1;
            phase         <= 2'd0;
            lpc.LpcBusOut <= LAD_IDLE;
          end else begin
            phase         <= phase + 2'd1;
            lpc.LpcBusOut <= wdata_q[7:4];
          end
        end

        // First TAR clock drives LAD high; the host releases LAD after it.
        TAR1: begin
          lpc.LpcBusOe <= 1'b0;
          if (phase == TAR_LAST) begin
            state <= SYNC;
            phase <= 2'd0;
          end else begin
            phase <= phase + 2'd1;
          end
        end

        SYNC: begin
          if (sync_abort) begin
            state           <= ABORT;
            phase           <= 2'd0;
            lpc.LpcFrameOut <= 1'b0;
            lpc.LpcBusOe    <= 1'b1;
            lpc.LpcBusOut   <= LAD_IDLE;
          end else if (sync_ready || sync_error) begin
            if (sync_error) begin
              err_q <= 1'b1;
            end
            phase <= 2'd0;
            state <= wr_q ? TAR2 : RDATA;
          end
        end

        RDATA: begin
          if (phase == DATA_LAST) begin
            data_q[7:4] <= lpc.LpcBusIn;
            state       <= TAR2;
            phase       <= 2'd0;
          end else begin
            data_q[3:0] <= lpc.LpcBusIn;
            phase       <= phase + 2'd1;
          end
        end

        // Writes leave RData alone; it always reflects the last completed read.
        TAR2: begin
          if (phase == TAR_LAST) begin
            state     <= IDLE;
            phase     <= 2'd0;
            lpc.Busy  <= 1'b0;
            lpc.Done  <= 1'b1;
            lpc.Error <= err_q;
            if (!wr_q) begin
              lpc.RData <= data_q;
            end
          end else begin
            phase <= phase + 2'd1;
          end
        end

        ABORT: begin
          if (phase == ABORT_LAST) begin
            state           <= IDLE;
            phase           <= 2'd0;
            lpc.Busy        <= 1'b0;
            lpc.Done        <= 1'b1;
            lpc.Error       <= 1'b1;
            lpc.LpcFrameOut <= 1'b1;
            lpc.LpcBusOe    <= 1'b0;
          end else begin
            phase <= phase + 2'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
